// File: rtl/pipelined_csa_pkg.sv
// Shared defaults and configuration legality helpers for the pipelined
// carry-select adder.
package pipelined_csa_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_BLK    = 4;
  localparam int unsigned DEF_STAGES = 2;

  function automatic int unsigned nblk(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

  // Whole blocks only, and every stage must own the same number of blocks.
  function automatic bit cfg_legal(input int unsigned width, input int unsigned blk,
                                   input int unsigned stages);
    if (blk == 0 || stages == 0) return 1'b0;
    if (width % blk != 0) return 1'b0;
    if (nblk(width, blk) < stages) return 1'b0;
    return (nblk(width, blk) % stages) == 0;
  endfunction

endpackage

// File: rtl/pipelined_csa_block.sv
// One BLK-bit carry-select slice: two ripple chains (carry-in 0 and 1),
// with the sum and carry-out picked by the resolved carry-in.
module csa_block
  import pipelined_csa_pkg::*;
#(
  parameter int unsigned BLK = DEF_BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0]   c0, c1;
  logic [BLK-1:0] s0, s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int unsigned i = 0; i < BLK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
    s  = ci ? s1 : s0;
    co = ci ? c1[BLK] : c0[BLK];
  end

endmodule

// File: rtl/pipelined_csa.sv
// Pipelined carry-select add/subtract with valid/ready backpressure.
// Define PIPELINED_CSA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_csa
  import pipelined_csa_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned BLK    = DEF_BLK,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_CSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NBLK = nblk(WIDTH, BLK);
  localparam int unsigned BPS  = NBLK / STAGES;
  localparam int unsigned SW   = BPS * BLK;

  if (!cfg_legal(WIDTH, BLK, STAGES)) begin : g_bad_cfg
    $error("pipelined_csa: WIDTH/BLK/STAGES combination is not legal");
  end

  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operands are kept relative to the first unresolved bit: bit 0 of a_in
    // is global bit k*SW, so each stage only carries what is still pending.
    localparam int unsigned UW = WIDTH - k * SW;
    localparam int unsigned RW = (k + 1) * SW;

    logic [UW-1:0] a_in, bx_in;
    logic          c_in, v_in;
    logic [SW-1:0] res;
    logic [RW-1:0] sum_d, sum_q;
    logic          c_d, c_q, v_d, v_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_in  = a;
        bx_in = b ^ {WIDTH{sub}};
        c_in  = sub | cin;
        v_in  = in_valid;
      end
    end else begin : g_src
      always_comb begin
        a_in  = g_stage[k-1].g_fwd.a_q;
        bx_in = g_stage[k-1].g_fwd.bx_q;
        c_in  = g_stage[k-1].c_q;
        v_in  = g_stage[k-1].v_q;
      end
    end

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      logic           ci, co;
      logic [BLK-1:0] s;

      if (j == 0) begin : g_ci
        always_comb ci = c_in;
      end else begin : g_ci
        always_comb ci = g_blk[j-1].co;
      end

      if (k == 0 && j == 0) begin : g_ripple
        always_comb {co, s} = {1'b0, a_in[BLK-1:0]} + {1'b0, bx_in[BLK-1:0]} + (BLK+1)'(ci);
      end else begin : g_sel
        csa_block #(.BLK(BLK)) u_blk (
          .a  (a_in[j*BLK +: BLK]),
          .b  (bx_in[j*BLK +: BLK]),
          .ci (ci),
          .s  (s),
          .co (co)
        );
      end

      assign res[j*BLK +: BLK] = s;
    end

    if (k == 0) begin : g_sum
      always_comb sum_d = res;
    end else begin : g_sum
      always_comb sum_d = {res, g_stage[k-1].sum_q};
    end

    always_comb begin
      v_d = v_in;
      c_d = g_blk[BPS-1].co;
    end

    // Payload loads only with a real beat, so bubbles leave the data untouched.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (adv) begin
        v_q <= v_d;
        if (v_d) begin
          sum_q <= sum_d;
          c_q   <= c_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [UW-SW-1:0] a_d, bx_d, a_q, bx_q;

      always_comb begin
        a_d  = a_in[UW-1:SW];
        bx_d = bx_in[UW-1:SW];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (adv && v_d) begin
          a_q  <= a_d;
          bx_q <= bx_d;
        end
      end
    end
  end

  always_comb begin
    out_valid = g_stage[STAGES-1].v_q;
    sum       = g_stage[STAGES-1].sum_q;
    cout      = g_stage[STAGES-1].c_q;
    adv       = !out_valid || out_ready;
    in_ready  = adv;
  end

`ifdef PIPELINED_CSA_OVF_EN
  logic ovf_d, ovf_q;

  // Carry into the MSB is recovered as a^bx^sum at that bit.
  always_comb ovf_d = g_stage[STAGES-1].a_in[SW-1] ^ g_stage[STAGES-1].bx_in[SW-1]
                    ^ g_stage[STAGES-1].sum_d[WIDTH-1] ^ g_stage[STAGES-1].c_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv && g_stage[STAGES-1].v_d) begin
      ovf_q <= ovf_d;
    end
  end

  always_comb ovf = ovf_q;
`endif

endmodule
